// File: rtl/segscan_decoder_if.sv
// Bus bundle between the 14-segment scan monitor and its reader.
// Optional SEGSCAN_ERRCNT_EN adds the saturating error counter output.
`timescale 1ns/1ps
interface segscan_decoder_if #(
  parameter int NDIG = 12,
  parameter int SEGW = 14,
  parameter int CW   = 7
);
  logic [NDIG-1:0] sel_in;
  logic [SEGW-1:0] segm_in;
  logic [3:0]      rd_idx;
  logic [CW-1:0]   rd_char;
  logic            frame_valid;
  logic            frame_ok;
  logic            err_scan;
  logic            err_glyph;
`ifdef SEGSCAN_ERRCNT_EN
  logic [7:0]      err_cnt;

  // Driver / reader side
  modport master (
    output sel_in, segm_in, rd_idx,
    input  rd_char, frame_valid, frame_ok, err_scan, err_glyph, err_cnt
  );

  // Decoder side
  modport slave (
    input  sel_in, segm_in, rd_idx,
    output rd_char, frame_valid, frame_ok, err_scan, err_glyph, err_cnt
  );
`else
  // Driver / reader side
  modport master (
    output sel_in, segm_in, rd_idx,
    input  rd_char, frame_valid, frame_ok, err_scan, err_glyph
  );

  // Decoder side
  modport slave (
    input  sel_in, segm_in, rd_idx,
    output rd_char, frame_valid, frame_ok, err_scan, err_glyph
  );
`endif
endinterface

// File: rtl/segscan_decoder.sv
// segscan_decoder: monitors a multiplexed 14-segment banner scan, decodes each
// glyph back to ASCII and assembles 12-digit frames in a shadow/committed
// double buffer. Scan-order and glyph errors are flagged as 1-cycle pulses.
// Optional feature macro: SEGSCAN_ERRCNT_EN (saturating 8-bit error counter).
`timescale 1ns/1ps
module segscan_decoder #(
  parameter int NDIG = 12,
  parameter int SEGW = 14,
  parameter int CW   = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  segscan_decoder_if.slave   bus
);

  localparam int IW = 4;
  localparam logic [0:0]    ST_HUNT  = 1'b0;
  localparam logic [0:0]    ST_CAPT  = 1'b1;
  localparam logic [CW-1:0] CH_SPACE = CW'(7'h20);
  localparam logic [CW-1:0] CH_QMARK = CW'(7'h3F);

  // Stage-1 sample registers
  logic [NDIG-1:0] sel_q;
  logic [SEGW-1:0] segm_q;

  // Frame tracking state
  logic [0:0]      state_q, state_d;
  logic [IW-1:0]   exp_q, exp_d;
  logic            gerr_q, gerr_d;

  // Double buffer
  logic [CW-1:0]   shadow_q [NDIG];
  logic [CW-1:0]   commit_q [NDIG];

  // Registered outputs
  logic            frame_valid_q, frame_valid_d;
  logic            frame_ok_q, frame_ok_d;
  logic            err_scan_q, err_scan_d;
  logic            err_glyph_q, err_glyph_d;

  // Stage-2 decode results
  logic [CW-1:0]   glyph_char;
  logic            glyph_bad;
  logic            sel_onehot;
  logic [IW-1:0]   sel_idx;
  logic            wr_en;
  logic            commit;

  // Stage 1: register the raw scan bus so nothing downstream sees live inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      segm_q <= '0;
    end else begin
      sel_q  <= bus.sel_in;
      segm_q <= bus.segm_in;
    end
  end

  // Glyph lookup: segment pattern back to ASCII, '?' for anything unknown
  always_comb begin
    logic [6:0] g;
    g         = 7'h3F;
    glyph_bad = 1'b0;
    case (segm_q)
      14'b00000000000000: g = 7'h20;
      14'b11101111000000: g = 7'h41; // A
      14'b11110001010010: g = 7'h42; // B
      14'b10011100000000: g = 7'h43; // C
      14'b11110000010010: g = 7'h44; // D
      14'b10011110000000: g = 7'h45; // E
      14'b10001110000000: g = 7'h46; // F
      14'b01101111000000: g = 7'h48; // H
      14'b10010000010010: g = 7'h49; // I
      14'b01111000000000: g = 7'h4A; // J
      14'b00011100000000: g = 7'h4C; // L
      14'b11001111000000: g = 7'h50; // P
      14'b11001111000100: g = 7'h52; // R
      14'b10000000010010: g = 7'h54; // T
      14'b01111100000000: g = 7'h55; // U
      default:            glyph_bad = 1'b1;
    endcase
    glyph_char = glyph_bad ? CH_QMARK : CW'(g);
  end

  // Digit select checks: one-hot test and binary index of the set bit
  always_comb begin
    sel_onehot = (sel_q != '0) && ((sel_q & (sel_q - NDIG'(1))) == '0);
    sel_idx    = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_q[i]) sel_idx = IW'(i);
    end
  end

  // Scan-order FSM: decides capture, commit and error pulses for this sample
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    gerr_d      = gerr_q;
    wr_en       = 1'b0;
    commit      = 1'b0;
    err_scan_d  = 1'b0;
    err_glyph_d = 1'b0;
    frame_ok_d  = frame_ok_q;

    // sel == 0 is a blanking slot: nothing moves
    if (sel_q != '0) begin
      case (state_q)
        ST_HUNT: begin
          if (!sel_onehot)          err_scan_d = 1'b1;
          else if (sel_idx == '0)   wr_en      = 1'b1;
        end
        default: begin
          if (sel_onehot && sel_idx == exp_q) begin
            wr_en = 1'b1;
          end else begin
            // Partial frame is abandoned; the offending sample is not reused
            err_scan_d = 1'b1;
            state_d    = ST_HUNT;
            exp_d      = '0;
            gerr_d     = 1'b0;
          end
        end
      endcase
    end

    if (wr_en) begin
      err_glyph_d = glyph_bad;
      // Digit 1 opens a fresh frame, so its glyph status restarts the flag
      gerr_d      = (sel_idx == '0) ? glyph_bad : (gerr_q | glyph_bad);
      state_d     = ST_CAPT;
      if (sel_idx == IW'(NDIG - 1)) begin
        commit     = 1'b1;
        exp_d      = '0;
        frame_ok_d = ~gerr_d;
      end else begin
        exp_d = sel_idx + IW'(1);
      end
    end

    frame_valid_d = commit;
  end

  // FSM state, per-frame glyph flag and output pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      exp_q         <= '0;
      gerr_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_ok_q    <= 1'b0;
      err_scan_q    <= 1'b0;
      err_glyph_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      gerr_q        <= gerr_d;
      frame_valid_q <= frame_valid_d;
      frame_ok_q    <= frame_ok_d;
      err_scan_q    <= err_scan_d;
      err_glyph_q   <= err_glyph_d;
    end
  end

  // Double buffer: shadow fills digit by digit, committed copy swaps in whole
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIG; i++) begin
        shadow_q[i] <= CH_SPACE;
        commit_q[i] <= CH_SPACE;
      end
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (wr_en && sel_idx == IW'(i)) shadow_q[i] <= glyph_char;
        // The last digit goes straight into the committed copy with the rest
        if (commit) commit_q[i] <= (i == NDIG - 1) ? glyph_char : shadow_q[i];
      end
    end
  end

  assign bus.rd_char     = (bus.rd_idx < IW'(NDIG)) ? commit_q[bus.rd_idx] : CH_SPACE;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_ok    = frame_ok_q;
  assign bus.err_scan    = err_scan_q;
  assign bus.err_glyph   = err_glyph_q;

`ifdef SEGSCAN_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of cycles carrying any error pulse
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_scan_d || err_glyph_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'h00;
    else        err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_segscan_decoder.sv
// Randomized bench for segscan_decoder with a sample-level reference model.
`timescale 1ns/1ps
module tb_segscan_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  segscan_decoder_if #(.NDIG(12), .SEGW(14), .CW(7)) bus ();

  segscan_decoder #(.NDIG(12), .SEGW(14), .CW(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Glyph tables
  byte         char_of [logic [13:0]];
  logic [13:0] seg_of  [byte];
  string       alpha = " ABCDEFHIJLPRTU";

  task automatic add_glyph(input logic [13:0] p, input byte c);
    char_of[p] = c;
    seg_of[c]  = p;
  endtask

  // Reference model state
  bit   m_hunt;
  int   m_exp;
  byte  m_shadow [12];
  byte  m_commit [12];
  bit   m_gerr, m_fo, m_fv, m_es, m_eg;
  int   m_cnt;
  logic [11:0] p_sel;
  logic [13:0] p_segm;

  task automatic model_reset();
    m_hunt = 1; m_exp = 0; m_gerr = 0; m_fo = 0;
    m_fv = 0; m_es = 0; m_eg = 0; m_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      m_shadow[i] = 8'h20;
      m_commit[i] = 8'h20;
    end
    p_sel = '0; p_segm = '0;
  endtask

  function automatic byte model_read(input int idx);
    return (idx < 12) ? m_commit[idx] : 8'h20;
  endfunction

  // One scan sample as it reaches the decoding stage
  task automatic model_step(input logic [11:0] sel, input logic [13:0] segm);
    int  idx;
    bit  onehot, bad, take;
    byte ch;
    m_fv = 0; m_es = 0; m_eg = 0; take = 0;
    if (sel != 0) begin
      onehot = ($countones(sel) == 1);
      idx = 0;
      for (int i = 0; i < 12; i++) if (sel[i]) idx = i;
      if (m_hunt) begin
        if (!onehot) m_es = 1;
        else if (idx == 0) take = 1;
      end else if (onehot && idx == m_exp) begin
        take = 1;
      end else begin
        m_es = 1; m_hunt = 1; m_exp = 0; m_gerr = 0;
      end
      if (take) begin
        bad = !char_of.exists(segm);
        ch  = bad ? 8'h3F : char_of[segm];
        m_eg = bad;
        m_shadow[idx] = ch;
        m_gerr = (idx == 0) ? bad : (m_gerr | bad);
        m_hunt = 0;
        if (idx == 11) begin
          m_commit = m_shadow;
          m_fv = 1; m_fo = !m_gerr; m_exp = 0;
        end else begin
          m_exp = idx + 1;
        end
      end
    end
    if ((m_es || m_eg) && m_cnt < 255) m_cnt++;
  endtask

  // Drive one sample at a negedge, check outputs just after the next posedge
  task automatic step(input logic [11:0] sel, input logic [13:0] segm);
    int    ridx;
    string s;
    ridx = $urandom_range(0, 15);
    bus.sel_in  = sel;
    bus.segm_in = segm;
    bus.rd_idx  = 4'(ridx);
    @(posedge clk); #1;
    model_step(p_sel, p_segm);
    p_sel = sel; p_segm = segm;
    check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    check("frame_ok",    32'(bus.frame_ok),    32'(m_fo));
    check("err_scan",    32'(bus.err_scan),    32'(m_es));
    check("err_glyph",   32'(bus.err_glyph),   32'(m_eg));
    check($sformatf("rd_char[%0d]", ridx), 32'(bus.rd_char), 32'(model_read(ridx)));
`ifdef SEGSCAN_ERRCNT_EN
    check("err_cnt", 32'(bus.err_cnt), 32'(m_cnt));
`endif
    if (m_fv) begin
      s = "";
      for (int i = 0; i < 16; i++) begin
        bus.rd_idx = 4'(i);
        #0.2;
        check($sformatf("frame_char[%0d]", i), 32'(bus.rd_char), 32'(model_read(i)));
        if (i < 12) s = $sformatf("%s%c", s, m_commit[i]);
      end
      $display("frame t=%0t text=\"%s\" ok=%0d", $time, s, m_fo);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst frame_ok",    32'(bus.frame_ok),    32'd0);
    check("rst err_scan",    32'(bus.err_scan),    32'd0);
    check("rst err_glyph",   32'(bus.err_glyph),   32'd0);
`ifdef SEGSCAN_ERRCNT_EN
    check("rst err_cnt",     32'(bus.err_cnt),     32'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      bus.rd_idx = 4'(i);
      #0.2;
      check($sformatf("rst rd_char[%0d]", i), 32'(bus.rd_char), 32'h20);
    end
    bus.sel_in = '0; bus.segm_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    p_sel = '0; p_segm = '0;
  endtask

  task automatic send_text(input string s, input int first, input int last);
    for (int d = first; d <= last; d++) step(12'(1) << d, seg_of[s[d]]);
  endtask

  task automatic rand_frames(input int n, input int p_blank, input int p_glyph, input int p_scan);
    logic [11:0] sel;
    logic [13:0] segm;
    for (int f = 0; f < n; f++) begin
      for (int d = 0; d < 12; d++) begin
        while ($urandom_range(0, 99) < p_blank) step('0, 14'($urandom));
        segm = seg_of[alpha[$urandom_range(0, 14)]];
        if ($urandom_range(0, 99) < p_glyph) segm = 14'($urandom);
        sel = 12'(1) << d;
        if ($urandom_range(0, 99) < p_scan) sel = 12'($urandom_range(1, 4095));
        step(sel, segm);
      end
    end
  endtask

  initial begin
    string jl = "JUPITER LAB ";
    add_glyph(14'b00000000000000, 8'h20);
    add_glyph(14'b11101111000000, "A");
    add_glyph(14'b11110001010010, "B");
    add_glyph(14'b10011100000000, "C");
    add_glyph(14'b11110000010010, "D");
    add_glyph(14'b10011110000000, "E");
    add_glyph(14'b10001110000000, "F");
    add_glyph(14'b01101111000000, "H");
    add_glyph(14'b10010000010010, "I");
    add_glyph(14'b01111000000000, "J");
    add_glyph(14'b00011100000000, "L");
    add_glyph(14'b11001111000000, "P");
    add_glyph(14'b11001111000100, "R");
    add_glyph(14'b10000000010010, "T");
    add_glyph(14'b01111100000000, "U");
    model_reset();
    bus.sel_in = '0; bus.segm_in = '0; bus.rd_idx = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Continuous banner loop
    repeat (3) send_text(jl, 0, 11);
    // Entry mid-frame at digit 5
    do_reset();
    send_text(jl, 4, 11);
    repeat (2) send_text(jl, 0, 11);
    // Two-hot select at digit 4, recovery on next digit 1
    send_text(jl, 0, 2);
    step(12'b000000000011, seg_of["I"]);
    send_text(jl, 4, 11);
    send_text(jl, 0, 11);
    // Unknown glyph on digit 3, then a clean frame
    send_text(jl, 0, 1);
    step(12'b000000000100, 14'h3FFF);
    send_text(jl, 3, 11);
    send_text(jl, 0, 11);
    // Blanking slots between digits
    rand_frames(4, 40, 0, 0);
    // Random text with occasional faults
    rand_frames(40, 15, 5, 4);
    // Reset at digit 7
    send_text(jl, 0, 6);
    do_reset();
    send_text(jl, 0, 11);
`ifdef SEGSCAN_ERRCNT_EN
    repeat (300) step(12'b000000000011, '0);
    check("err_cnt sat", 32'(bus.err_cnt), 32'hFF);
    do_reset();
    step('0, '0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
